// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - multiply/divide issue, latency countdown and D-stage stall control
// Optional MD_STALL_CNT_EN builds a saturating stall-cycle counter; otherwise stall_cnt is 0.
module md_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_use,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic        e_flush,
  output logic        md_start,
  output logic [2:0]  md_ctrl,
  output logic        busy,
  output logic [3:0]  remaining,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nx;
  logic [3:0] count, count_nx;
  logic       ok, is_issue_op, is_move_op;

  assign ok          = e_valid && !e_flush;
  assign is_issue_op = (e_op >= 3'd1) && (e_op <= 3'd4);
  assign is_move_op  = (e_op == 3'd5) || (e_op == 3'd6);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    md_start = 1'b0;
    md_ctrl  = 3'd0;
    case (state)
      IDLE: begin
        if (ok && is_issue_op) begin
          md_start = !reset;
          md_ctrl  = e_op;
          state_nx = RUN;
          count_nx = (e_op <= 3'd2) ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
        end
      end
      RUN: begin
        // Issue attempts here are dropped; the countdown runs to completion regardless.
        count_nx = count - 4'd1;
        if (count == 4'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (ok && is_move_op) md_ctrl = e_op;
  end

  assign busy      = (state == RUN);
  assign remaining = count;
  assign stall     = d_md_use && (md_start || busy);

`ifdef MD_STALL_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 32'd0;
    else if (stall && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
  end
  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - table-driven bench for md_issue_ctrl with an expected-result queue
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, d_md_use, e_valid, e_flush;
  logic [2:0]  e_op;
  logic        md_start, busy, stall;
  logic [2:0]  md_ctrl;
  logic [3:0]  remaining;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .d_md_use(d_md_use), .e_valid(e_valid), .e_op(e_op),
    .e_flush(e_flush), .md_start(md_start), .md_ctrl(md_ctrl), .busy(busy),
    .remaining(remaining), .stall(stall), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        rst, dmd, ev;
    logic [2:0]  op;
    logic        fl;
    logic        st;
    logic [2:0]  ctrl;
    logic        bsy;
    logic [3:0]  rem;
    logic        stl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt_model = 0;

  task automatic add(input logic rst, dmd, ev, input logic [2:0] op, input logic fl,
                     input logic st, input logic [2:0] ctrl, input logic bsy,
                     input logic [3:0] rem, input logic stl);
    vec_t v;
    v.rst = rst; v.dmd = dmd; v.ev = ev; v.op = op; v.fl = fl;
    v.st = st; v.ctrl = ctrl; v.bsy = bsy; v.rem = rem; v.stl = stl;
`ifdef MD_STALL_CNT_EN
    v.cnt = 32'(cnt_model);
`else
    v.cnt = 32'd0;
`endif
    if (rst) cnt_model = 0;
    else if (stl) cnt_model++;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;
    reset = 1'b1; d_md_use = 1'b0; e_valid = 1'b0; e_op = 3'd0; e_flush = 1'b0;
    repeat (2) @(posedge clk);

    add(1,0,0,0,0, 0,0,0,0,0);
    // single mult
    add(0,0,1,1,0, 1,1,0,0,0);
    for (int k = 5; k >= 1; k--) add(0,0,0,0,0, 0,0,1,4'(k),0);
    add(0,0,0,0,0, 0,0,0,0,0);
    // move and reserved ops while idle
    add(0,0,1,6,0, 0,6,0,0,0);
    add(0,0,1,7,0, 0,0,0,0,0);
    add(0,0,0,5,0, 0,0,0,0,0);
    add(0,0,1,5,0, 0,5,0,0,0);
    // flushed div
    add(0,1,1,3,1, 0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0);
    // div with MD user held in D
    add(0,1,1,3,0, 1,3,0,0,1);
    for (int k = 10; k >= 1; k--) add(0,1,0,0,0, 0,0,1,4'(k),1);
    add(0,1,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0);
    // divu in flight, no MD user; illegal issue and a move during RUN
    add(0,0,1,4,0, 1,4,0,0,0);
    for (int k = 10; k >= 8; k--) add(0,0,0,0,0, 0,0,1,4'(k),0);
    add(0,0,1,1,0, 0,0,1,7,0);
    add(0,0,1,5,0, 0,5,1,6,0);
    for (int k = 5; k >= 1; k--) add(0,0,0,0,0, 0,0,1,4'(k),0);
    add(0,0,0,0,0, 0,0,0,0,0);
    // reset with an issue presented: start suppressed, ctrl follows
    add(1,0,1,1,0, 0,1,0,0,0);
    // reset mid-operation, then a fresh multu/mult
    add(0,1,1,2,0, 1,2,0,0,1);
    add(0,1,0,0,0, 0,0,1,5,1);
    add(0,1,0,0,0, 0,0,1,4,1);
    add(1,1,0,0,0, 0,0,1,3,1);
    add(0,1,1,1,0, 1,1,0,0,1);
    for (int k = 5; k >= 1; k--) add(0,1,0,0,0, 0,0,1,4'(k),1);
    add(0,0,0,0,0, 0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      reset = v.rst; d_md_use = v.dmd; e_valid = v.ev; e_op = v.op; e_flush = v.fl;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("md_start",  i, 32'(md_start),  32'(e.st));
      chk("md_ctrl",   i, 32'(md_ctrl),   32'(e.ctrl));
      chk("busy",      i, 32'(busy),      32'(e.bsy));
      chk("remaining", i, 32'(remaining), 32'(e.rem));
      chk("stall",     i, 32'(stall),     32'(e.stl));
      chk("stall_cnt", i, stall_cnt,      e.cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and stall controller for the multiply/divide unit in the five-stage MIPS pipeline. It decodes the E-stage multiply/divide opcode and drives the unit's start pulse and control code. It also keeps its own latency countdown, so the busy condition is known before the unit's result lands. From that countdown it generates the D-stage stall that stops HI/LO users from advancing while an operation is in flight.

## Interface
- MUL_CYCLES, 5: busy cycles after a mult/multu issue.
- DIV_CYCLES, 10: busy cycles after a div/divu issue.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- d_md_use  in  1  the D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- e_valid  in  1  the E-stage instruction is real, not a bubble.
- e_op  in  3  E-stage multiply/divide opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- e_flush  in  1  the E-stage instruction is being killed this cycle.
- md_start  out  1  start pulse to the unit.
- md_ctrl  out  3  control code to the unit.
- busy  out  1  a mult or div operation is in flight.
- remaining  out  4  countdown value; 0 when idle.
- stall  out  1  freeze F/D and insert a bubble into E.
- stall_cnt  out  32  stall-cycle counter (see Configuration).

## Operation
- Two states:
  - IDLE: counter = 0.
  - RUN: counter = 1..DIV_CYCLES.
- Definition: ok = e_valid && !e_flush.
- Issue:
  - Condition: ok, e_op in 1..4, and state IDLE.
  - Outputs (combinational): md_start = 1, md_ctrl = e_op.
  - Next edge: state moves to RUN; counter loads MUL_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
- Move ops:
  - Condition: ok and e_op in 5..6.
  - Outputs: md_ctrl = e_op, md_start = 0, no state change.
- Default: in all other cases md_ctrl = 0 and md_start = 0.
- Issue attempt while in RUN:
  - This is a protocol violation that the stall normally prevents.
  - Response: the op is ignored, md_start = 0, md_ctrl = 0, and the countdown is undisturbed.
- RUN behaviour:
  - The counter decrements every cycle.
  - When counter == 1, the next state is IDLE. The unit commits HI/LO on that same edge.
- Outputs in RUN: busy = (state == RUN) and remaining = counter.
- Stall: stall = d_md_use && (md_start || busy).
- Flush:
  - e_flush only suppresses an issue in the same cycle.
  - An operation already in RUN always completes; it is never cancelled.
- Reset:
  - Forces IDLE with counter 0, busy 0, remaining 0, and stall_cnt 0.
  - Applies mid-operation as well, with no partial completion.
  - Combinational outputs follow their inputs during reset, except that md_start is forced to 0.

## Timing
- md_start and md_ctrl are combinational from e_valid, e_op, e_flush and state, in the same cycle as the issue.
- For an issue in cycle T with latency N:
  - busy = 1 in cycles T+1..T+N.
  - remaining = N, N-1, …, 1 over those cycles.
  - busy = 0 from T+N+1.
- HI/LO are valid from cycle T+N+1.
- For an MD-using instruction in D: stall = 1 in cycles T..T+N, and the instruction advances at the T+N+1 edge.
- Back-to-back operations: a second mult or div can issue in E no earlier than cycle T+N+2.
- Non-MD instructions never stall because of this block.

## Configuration
- MD_STALL_CNT_EN:
  - Defined: stall_cnt increments on every clock where stall = 1, saturates at 32'hFFFF_FFFF, and is cleared by reset.
  - Undefined: stall_cnt is tied to 0 and no counter register is built.

## Test plan
- Single mult: reset, then e_valid=1 and e_op=1 at cycle T.
  - Cycle T: md_start=1, md_ctrl=1.
  - Cycles T+1..T+5: busy=1 with remaining 5, 4, 3, 2, 1.
  - Cycle T+6: busy=0, remaining=0.
- Div stall with MD_STALL_CNT_EN defined: div issued at cycle T with d_md_use held at 1.
  - stall=1 in cycles T..T+10, stall=0 at T+11.
  - stall_cnt=11 afterwards.
- Flush: e_op=3, e_valid=1, e_flush=1.
  - md_start=0, md_ctrl=0, busy stays 0.
  - With d_md_use=1, stall=0.
- Reset mid-operation: mult issued at T, reset=1 at T+3.
  - At T+4: busy=0, remaining=0, stall=0.
  - A new mult at T+4 issues normally with md_start=1.
- Move and reserved ops while idle:
  - e_op=6: md_ctrl=6, md_start=0, busy=0.
  - e_op=7: md_ctrl=0.
  - e_op=5 with e_valid=0: md_ctrl=0.
- Busy isolation: div in flight, d_md_use=0 → stall=0 every cycle. Illegal e_op=1 injected at T+4 → md_start=0 and the countdown is unchanged.
